// File: rtl/pc_sequencer_pkg.sv
// Shared front-end definitions: sequencer state encoding, redirect priority tags
// and default boot/exception addresses.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

  // Numeric order is the arbitration order, so tags compare directly with >=.
  typedef enum logic [1:0] {
    PRI_NONE   = 2'd0,
    PRI_JUMP   = 2'd1,
    PRI_BRANCH = 2'd2,
    PRI_EXC    = 2'd3
  } redir_pri_e;

  localparam logic [31:0] DEF_BOOT_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0080;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority select of the redirect target: exception > EX branch > ID jump.
module pc_redirect_arb
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic        exc_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        redir_v,
  output logic [31:0] redir_target,
  output redir_pri_e  redir_tag
);

  always_comb begin
    redir_v      = 1'b1;
    redir_target = 32'h0;
    redir_tag    = PRI_NONE;
    if (exc_req) begin
      redir_target = EXC_VEC;
      redir_tag    = PRI_EXC;
    end else if (branch_taken) begin
      redir_target = branch_target;
      redir_tag    = PRI_BRANCH;
    end else if (jump_valid) begin
      redir_target = jump_target;
      redir_tag    = PRI_JUMP;
    end else begin
      redir_v = 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register input, raises PC stall and pipeline
// flushes, and parks a redirect that arrives while instruction memory is busy.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = DEF_BOOT_PC,
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [31:0]      PC_Cur,
  input  logic             JUMP_Valid,
  input  logic [31:0]      JUMP_Target,
  input  logic             BRANCH_Taken,
  input  logic [31:0]      BRANCH_Target,
  input  logic             EXC_Req,
  input  logic             LOAD_USE,
  input  logic             MEM_Busy,
  input  logic             HALT_Req,
  output logic [31:0]      PC_Next,
  output logic             PC_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Halted,
  output logic [CNT_W-1:0] Stall_Count
);

  seq_state_e       state_q, state_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  redir_pri_e       pend_tag_q, pend_tag_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             arb_v;
  logic [31:0]      arb_target;
  redir_pri_e       arb_tag;
  logic             new_redir;
  logic             take_new;
  logic             pc_stall;

  pc_redirect_arb #(
    .EXC_VEC(EXC_VEC)
  ) u_arb (
    .exc_req      (EXC_Req),
    .branch_taken (BRANCH_Taken),
    .branch_target(BRANCH_Target),
    .jump_valid   (JUMP_Valid),
    .jump_target  (JUMP_Target),
    .redir_v      (arb_v),
    .redir_target (arb_target),
    .redir_tag    (arb_tag)
  );

  always_comb begin
    // While halted only an exception is allowed to redirect.
    new_redir   = arb_v && ((state_q != ST_HALT) || EXC_Req);
    take_new    = new_redir && (!pend_v_q || (arb_tag >= pend_tag_q));

    state_d     = state_q;
    pend_v_d    = pend_v_q;
    pend_pc_d   = pend_pc_q;
    pend_tag_d  = pend_tag_q;
    stall_cnt_d = stall_cnt_q;

    PC_Next     = seq_pc(PC_Cur);
    pc_stall    = 1'b0;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Halted      = 1'b0;

    if (RESET) begin
      state_d     = ST_BOOT;
      pend_v_d    = 1'b0;
      pend_pc_d   = 32'h0;
      pend_tag_d  = PRI_NONE;
      stall_cnt_d = '0;
      PC_Next     = BOOT_PC;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          PC_Next = BOOT_PC;
          state_d = ST_RUN;
        end
        default: begin
          if (new_redir) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = (arb_tag != PRI_JUMP);
          end
          if ((state_q == ST_HALT) && !EXC_Req) begin
            pc_stall = 1'b1;
            Halted   = 1'b1;
            PC_Next  = PC_Cur;
          end else if (MEM_Busy) begin
            pc_stall = 1'b1;
            PC_Next  = PC_Cur;
            state_d  = ST_HOLD;
            if (take_new) begin
              pend_v_d   = 1'b1;
              pend_pc_d  = arb_target;
              pend_tag_d = arb_tag;
            end
          end else begin
            state_d    = ST_RUN;
            pend_v_d   = 1'b0;
            pend_tag_d = PRI_NONE;
            if (take_new) begin
              PC_Next = arb_target;
            end else if (pend_v_q) begin
              PC_Next = pend_pc_q;
            end else if (LOAD_USE) begin
              pc_stall    = 1'b1;
              ID_EX_Flush = 1'b1;
              PC_Next     = PC_Cur;
            end
          end
          if ((state_q != ST_HALT) && HALT_Req && !EXC_Req) begin
            state_d    = ST_HALT;
            pend_v_d   = 1'b0;
            pend_tag_d = PRI_NONE;
          end
        end
      endcase
      if (pc_stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    state_q     <= state_d;
    pend_v_q    <= pend_v_d;
    pend_pc_q   <= pend_pc_d;
    pend_tag_q  <= pend_tag_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign PC_Stall    = pc_stall;
  assign Stall_Count = stall_cnt_q;

endmodule
